// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the hazard controller of the 5-stage RISC-V core:
//   - REG_AW_DEFAULT : default register-index width
//   - res_src_e      : ResultSrc encodings (ALU / memory load / PC+4)
//   - fwd_e          : ALU operand forward selects (RF / W / M)
//   - mc_state_e     : multi-cycle execute FSM states
//   - fwd_select()   : priority forwarding decision for one operand
// -----------------------------------------------------------------------------
package hazard_pkg;

  localparam int REG_AW_DEFAULT = 5;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } res_src_e;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mc_state_e;

  // x0 never forwards; M is younger than W so it wins when both match.
  function automatic fwd_e fwd_select(input logic rs_nonzero,
                                      input logic hit_m,
                                      input logic hit_w);
    fwd_e sel;
    sel = FWD_RF;
    if (rs_nonzero) begin
      if (hit_m) begin
        sel = FWD_M;
      end else if (hit_w) begin
        sel = FWD_W;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_unit_mc_if.sv
// -----------------------------------------------------------------------------
// hazard_unit_mc_if
// Bundle between the pipeline datapath and the hazard controller.
//   Parameters: REG_AW (register index width), CNT_W (perf counter width).
//   Stage info  (datapath -> hazard): Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
//                                     RegWriteM, RegWriteW, ResultSrcE,
//                                     PCSrcE, McStartE
//   Controls    (hazard -> datapath): StallF/D/E, FlushD/E/M,
//                                     ForwardAE, ForwardBE, McBusyE
//   Perf        (hazard -> datapath): PerfStallCnt, PerfFlushCnt, PerfMcCnt,
//                                     present only when HAZARD_PERF_EN is defined
//   modport master : the hazard controller (drives the stage controls)
//   modport slave  : the datapath side
// -----------------------------------------------------------------------------
interface hazard_unit_mc_if
  import hazard_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEFAULT,
  parameter int CNT_W  = 32
);

  logic [REG_AW-1:0] Rs1D, Rs2D;
  logic [REG_AW-1:0] Rs1E, Rs2E, RdE;
  logic [REG_AW-1:0] RdM, RdW;
  logic              RegWriteM, RegWriteW;
  logic [1:0]        ResultSrcE;
  logic              PCSrcE;
  logic              McStartE;

  logic              StallF, StallD, StallE;
  logic              FlushD, FlushE, FlushM;
  logic [1:0]        ForwardAE, ForwardBE;
  logic              McBusyE;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0]  PerfStallCnt, PerfFlushCnt, PerfMcCnt;

  modport master (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  RegWriteM, RegWriteW, ResultSrcE, PCSrcE, McStartE,
    output StallF, StallD, StallE, FlushD, FlushE, FlushM,
    output ForwardAE, ForwardBE, McBusyE,
    output PerfStallCnt, PerfFlushCnt, PerfMcCnt
  );

  modport slave (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output RegWriteM, RegWriteW, ResultSrcE, PCSrcE, McStartE,
    input  StallF, StallD, StallE, FlushD, FlushE, FlushM,
    input  ForwardAE, ForwardBE, McBusyE,
    input  PerfStallCnt, PerfFlushCnt, PerfMcCnt
  );
`else
  modport master (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  RegWriteM, RegWriteW, ResultSrcE, PCSrcE, McStartE,
    output StallF, StallD, StallE, FlushD, FlushE, FlushM,
    output ForwardAE, ForwardBE, McBusyE
  );

  modport slave (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output RegWriteM, RegWriteW, ResultSrcE, PCSrcE, McStartE,
    input  StallF, StallD, StallE, FlushD, FlushE, FlushM,
    input  ForwardAE, ForwardBE, McBusyE
  );
`endif

endinterface

// File: rtl/mc_stall_ctrl.sv
// -----------------------------------------------------------------------------
// mc_stall_ctrl
// Holds a multi-cycle execute op in E for MC_LAT cycles.
//   clk        in  core clock
//   rst        in  synchronous active-low reset
//   McStartE_i in  instruction in E is multi-cycle
//   mcStall_o  out hold F/D/E and bubble M this cycle
//   McBusyE_o  out FSM is in BUSY
// The stall is raised combinationally in the IDLE/start cycle, then for
// MC_LAT-2 BUSY cycles; the last BUSY cycle releases the op.
// -----------------------------------------------------------------------------
module mc_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int MC_LAT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic McStartE_i,
  output logic mcStall_o,
  output logic McBusyE_o
);

  // MC_LAT of 1 or 2 still gets a 1-bit counter so the vector stays legal.
  localparam int            CW       = (MC_LAT > 2) ? $clog2(MC_LAT) : 1;
  localparam bit            MC_EN    = (MC_LAT >= 2);
  localparam logic [CW-1:0] CNT_LOAD = CW'((MC_LAT >= 2) ? (MC_LAT - 2) : 0);

  mc_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (MC_EN && McStartE_i) begin
          state_d = BUSY;
          cnt_d   = CNT_LOAD;
        end
      end
      BUSY: begin
        // McStartE stays high while the op is held; it is ignored here so a
        // following multi-cycle op re-triggers from IDLE.
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mcStall_o = 1'b0;
    McBusyE_o = (state_q == BUSY);
    unique case (state_q)
      IDLE:    mcStall_o = MC_EN && McStartE_i;
      BUSY:    mcStall_o = (cnt_q != '0);
      default: mcStall_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/hazard_unit_mc.sv
// -----------------------------------------------------------------------------
// hazard_unit_mc
// Hazard controller for the 5-stage RISC-V core with a multi-cycle execute
// unit: M/W operand forwarding, load-use stall, branch flush and a hold of
// F/D/E (with an M bubble) while a mul/div op occupies E.
//   Parameters: REG_AW (register index width), MC_LAT (E occupancy of a
//               multi-cycle op, >=1), CNT_W (perf counter width)
//   clk  in  core clock
//   rst  in  synchronous active-low reset; all outputs read 0 while low
//   hz   hazard_unit_mc_if.master: stage info in, stall/flush/forward out
// Optional feature macro: HAZARD_PERF_EN adds saturating counters
//   PerfStallCnt (cycles with StallF), PerfFlushCnt (cycles with PCSrcE),
//   PerfMcCnt (IDLE->BUSY transitions).
// -----------------------------------------------------------------------------
module hazard_unit_mc
  import hazard_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEFAULT,
  parameter int MC_LAT = 8,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  hazard_unit_mc_if.master hz
);

  localparam logic [REG_AW-1:0] X0 = '0;

  // ---------------------------------------------------------------- forwarding
  logic [REG_AW-1:0] rs_e [2];
  fwd_e              fwd  [2];

  assign rs_e[0] = hz.Rs1E;
  assign rs_e[1] = hz.Rs2E;

  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    assign fwd[gi] = fwd_select(rs_e[gi] != X0,
                                hz.RegWriteM && (rs_e[gi] == hz.RdM),
                                hz.RegWriteW && (rs_e[gi] == hz.RdW));
  end

  // ---------------------------------------------------------------- stalls
  logic lw_stall;
  logic mc_stall;
  logic mc_busy;

  assign lw_stall = (hz.ResultSrcE == RES_MEM) && (hz.RdE != X0) &&
                    ((hz.Rs1D == hz.RdE) || (hz.Rs2D == hz.RdE));

  mc_stall_ctrl #(
    .MC_LAT (MC_LAT)
  ) u_mc_stall_ctrl (
    .clk        (clk),
    .rst        (rst),
    .McStartE_i (hz.McStartE),
    .mcStall_o  (mc_stall),
    .McBusyE_o  (mc_busy)
  );

  // ---------------------------------------------------------------- outputs
  // Every output is qualified by rst so the datapath sees a quiet controller
  // for the whole reset window, not just after the first edge.
  logic stall_fd;
  assign stall_fd = lw_stall | mc_stall;

  assign hz.StallF    = rst & stall_fd;
  assign hz.StallD    = rst & stall_fd;
  assign hz.StallE    = rst & mc_stall;
  assign hz.FlushM    = rst & mc_stall;
  assign hz.FlushD    = rst & hz.PCSrcE;
  // A held multi-cycle op must not be wiped by the load-use bubble.
  assign hz.FlushE    = rst & (hz.PCSrcE | (lw_stall & ~mc_stall));
  assign hz.McBusyE   = rst & mc_busy;
  assign hz.ForwardAE = rst ? 2'(fwd[0]) : 2'b00;
  assign hz.ForwardBE = rst ? 2'(fwd[1]) : 2'b00;

`ifdef HAZARD_PERF_EN
  // ---------------------------------------------------------------- perf
  // Stalling while still IDLE is exactly the cycle that enters BUSY.
  logic [2:0] perf_inc;
  assign perf_inc[0] = stall_fd;
  assign perf_inc[1] = hz.PCSrcE;
  assign perf_inc[2] = mc_stall & ~mc_busy;

  for (genvar gi = 0; gi < 3; gi++) begin : g_perf
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (perf_inc[gi] && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (!rst) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end
  end

  assign hz.PerfStallCnt = rst ? g_perf[0].cnt_q : '0;
  assign hz.PerfFlushCnt = rst ? g_perf[1].cnt_q : '0;
  assign hz.PerfMcCnt    = rst ? g_perf[2].cnt_q : '0;
`endif

endmodule

// File: tb/tb_hazard_unit_mc.sv
// -----------------------------------------------------------------------------
// tb_hazard_unit_mc
// Directed vectors for hazard_unit_mc (MC_LAT=8). Each stimulus cycle pushes
// its hand-derived output word into a queue; a monitor on the falling edge
// pops and compares against the live DUT outputs.
// Output word: {StallF,StallD,StallE,FlushD,FlushE,FlushM,FwdA[1:0],FwdB[1:0],McBusyE}
// -----------------------------------------------------------------------------
module tb_hazard_unit_mc;
  import hazard_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  hazard_unit_mc_if #(.REG_AW(5), .CNT_W(32)) hz ();

  hazard_unit_mc #(
    .REG_AW (5),
    .MC_LAT (8),
    .CNT_W  (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  typedef struct {
    string       name;
    logic [10:0] exp;
  } item_t;

  item_t q[$];
  int    n_checks = 0;
  int    n_pass   = 0;

  function automatic logic [10:0] mk(input bit sf, input bit sd, input bit se,
                                     input bit fd, input bit fe, input bit fm,
                                     input logic [1:0] fa, input logic [1:0] fb,
                                     input bit busy);
    return {sf, sd, se, fd, fe, fm, fa, fb, busy};
  endfunction

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    hz.Rs1D = '0; hz.Rs2D = '0;
    hz.Rs1E = '0; hz.Rs2E = '0; hz.RdE = '0;
    hz.RdM  = '0; hz.RdW  = '0;
    hz.RegWriteM = 1'b0; hz.RegWriteW = 1'b0;
    hz.ResultSrcE = 2'b00;
    hz.PCSrcE = 1'b0;
    hz.McStartE = 1'b0;
  endtask

  task automatic chk(input string n, input logic [10:0] e);
    item_t it;
    it.name = n;
    it.exp  = e;
    q.push_back(it);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    item_t       it;
    logic [10:0] act;
    if (q.size() != 0) begin
      it  = q.pop_front();
      act = {hz.StallF, hz.StallD, hz.StallE, hz.FlushD, hz.FlushE, hz.FlushM,
             hz.ForwardAE, hz.ForwardBE, hz.McBusyE};
      n_checks++;
      if (act !== it.exp) begin
        $display("FAIL %s: got %b required %b", it.name, act, it.exp);
      end else begin
        n_pass++;
        $display("ok   %s: %b", it.name, act);
      end
    end
  end

  initial begin
    clr_in();
    rst = 1'b0;

    // Reset: everything reads 0 even with live hazard inputs.
    nxt(); hz.Rs1E = 5; hz.RdM = 5; hz.RegWriteM = 1'b1;
           hz.McStartE = 1'b1; hz.PCSrcE = 1'b1;
           chk("rst_forced_a", mk(0,0,0,0,0,0,2'b00,2'b00,0));
    nxt(); chk("rst_forced_b", mk(0,0,0,0,0,0,2'b00,2'b00,0));
    nxt(); rst = 1'b1; clr_in();
           chk("idle", mk(0,0,0,0,0,0,2'b00,2'b00,0));

    // Forwarding
    nxt(); clr_in(); hz.Rs1E = 5; hz.RdM = 5; hz.RegWriteM = 1'b1;
           hz.RdW = 5; hz.RegWriteW = 1'b1;
           chk("fwd_m_prio", mk(0,0,0,0,0,0,2'b10,2'b00,0));
    nxt(); clr_in(); hz.Rs1E = 5; hz.RdM = 5; hz.RegWriteM = 1'b0;
           hz.RdW = 5; hz.RegWriteW = 1'b1;
           chk("fwd_w", mk(0,0,0,0,0,0,2'b01,2'b00,0));
    nxt(); clr_in(); hz.Rs1E = 0; hz.RdM = 0; hz.RegWriteM = 1'b1;
           hz.RdW = 0; hz.RegWriteW = 1'b1;
           chk("fwd_x0", mk(0,0,0,0,0,0,2'b00,2'b00,0));
    nxt(); clr_in(); hz.Rs1E = 3; hz.Rs2E = 9; hz.RdM = 3; hz.RegWriteM = 1'b1;
           hz.RdW = 9; hz.RegWriteW = 1'b1;
           chk("fwd_a_m_b_w", mk(0,0,0,0,0,0,2'b10,2'b01,0));
    nxt(); clr_in(); hz.Rs2E = 12; hz.RdM = 12; hz.RdW = 12;
           chk("fwd_no_we", mk(0,0,0,0,0,0,2'b00,2'b00,0));

    // Load-use
    nxt(); clr_in(); hz.ResultSrcE = 2'b01; hz.RdE = 7; hz.Rs2D = 7;
           chk("lw_stall", mk(1,1,0,0,1,0,2'b00,2'b00,0));
    nxt(); clr_in();
           chk("lw_after", mk(0,0,0,0,0,0,2'b00,2'b00,0));
    nxt(); clr_in(); hz.ResultSrcE = 2'b01; hz.RdE = 0;
           chk("lw_rd0", mk(0,0,0,0,0,0,2'b00,2'b00,0));
    nxt(); clr_in(); hz.ResultSrcE = 2'b00; hz.RdE = 7; hz.Rs1D = 7;
           chk("alu_no_stall", mk(0,0,0,0,0,0,2'b00,2'b00,0));

    // Branch flush
    nxt(); clr_in(); hz.PCSrcE = 1'b1;
           chk("branch", mk(0,0,0,1,1,0,2'b00,2'b00,0));
    nxt(); clr_in(); hz.PCSrcE = 1'b1; hz.ResultSrcE = 2'b01; hz.RdE = 4; hz.Rs1D = 4;
           chk("branch_lw", mk(1,1,0,1,1,0,2'b00,2'b00,0));

    // Single multi-cycle op; a load-use pattern mid-hold must not flush E.
    for (int k = 0; k < 8; k++) begin
      nxt(); clr_in(); hz.McStartE = 1'b1;
      if (k == 3) begin
        hz.ResultSrcE = 2'b01; hz.RdE = 6; hz.Rs1D = 6;
      end
      chk($sformatf("mc_c%0d", k), mk(k < 7, k < 7, k < 7, 0, 0, k < 7, 2'b00, 2'b00, k >= 1));
    end
    nxt(); clr_in(); chk("mc_done", mk(0,0,0,0,0,0,2'b00,2'b00,0));

    // Back-to-back: IDLE for exactly one cycle (k=8) between the two ops.
    for (int k = 0; k < 16; k++) begin
      nxt(); clr_in(); hz.McStartE = 1'b1;
      chk($sformatf("b2b_c%0d", k),
          mk((k % 8) < 7, (k % 8) < 7, (k % 8) < 7, 0, 0, (k % 8) < 7, 2'b00, 2'b00, (k % 8) >= 1));
    end
    nxt(); clr_in(); chk("b2b_done", mk(0,0,0,0,0,0,2'b00,2'b00,0));

    // Reset on the 3rd BUSY cycle aborts the op.
    for (int k = 0; k < 3; k++) begin
      nxt(); clr_in(); hz.McStartE = 1'b1;
      chk($sformatf("abort_c%0d", k), mk(1,1,1,0,0,1,2'b00,2'b00,k >= 1));
    end
    nxt(); clr_in(); hz.McStartE = 1'b1; rst = 1'b0;
           chk("abort_rst", mk(0,0,0,0,0,0,2'b00,2'b00,0));
    nxt(); clr_in(); rst = 1'b1;
           chk("abort_idle", mk(0,0,0,0,0,0,2'b00,2'b00,0));

    // Fresh op after the abort starts from IDLE.
    for (int k = 0; k < 8; k++) begin
      nxt(); clr_in(); hz.McStartE = 1'b1;
      chk($sformatf("restart_c%0d", k), mk(k < 7, k < 7, k < 7, 0, 0, k < 7, 2'b00, 2'b00, k >= 1));
    end

    // PCSrcE and McStartE together: flushes follow the equations, FSM starts.
    for (int k = 0; k < 8; k++) begin
      nxt(); clr_in(); hz.McStartE = 1'b1;
      if (k == 0) hz.PCSrcE = 1'b1;
      chk($sformatf("br_mc_c%0d", k),
          mk(k < 7, k < 7, k < 7, k == 0, k == 0, k < 7, 2'b00, 2'b00, k >= 1));
    end
    nxt(); clr_in(); chk("final_idle", mk(0,0,0,0,0,0,2'b00,2'b00,0));

`ifdef HAZARD_PERF_EN
    // Since the abort reset: 7+7 stall cycles, 1 branch cycle, 2 starts.
    nxt();
    n_checks++;
    if (hz.PerfStallCnt !== 32'd14) $display("FAIL perf_stall: got %0d required 14", hz.PerfStallCnt);
    else begin n_pass++; $display("ok   perf_stall: %0d", hz.PerfStallCnt); end
    n_checks++;
    if (hz.PerfFlushCnt !== 32'd1) $display("FAIL perf_flush: got %0d required 1", hz.PerfFlushCnt);
    else begin n_pass++; $display("ok   perf_flush: %0d", hz.PerfFlushCnt); end
    n_checks++;
    if (hz.PerfMcCnt !== 32'd2) $display("FAIL perf_mc: got %0d required 2", hz.PerfMcCnt);
    else begin n_pass++; $display("ok   perf_mc: %0d", hz.PerfMcCnt); end
`endif

    // Let the monitor drain, with a bounded wait.
    for (int i = 0; i < 20 && q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: got %0d pending items required 0", q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
